fpcvt_iter: RTL and testbench
=============================

FPCVT_ITER -- requirements
Module: fpcvt_iter

Interface
REQ-001 SHALL have parameter DW, default 12: two's-complement input width.
REQ-002 SHALL have parameter EW, default 3: exponent width.
REQ-003 SHALL have parameter MW, default 4: significand width; elaboration SHALL fail unless DW == MW + 2**EW.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  D holds a sample to convert.
REQ-007 in_ready  output  1  block idle, accepts D this cycle.
REQ-008 D  input  DW  two's-complement sample.
REQ-009 out_valid  output  1  S/E/F hold a finished result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 S  output  1  sign; E  output  EW  exponent; F  output  MW  significand; value = (-1)^S * F * 2^E.

Function
REQ-012 SHALL use FSM states IDLE, NORM, ROUND, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 IDLE: in_valid=1 accepts; registers S = D[DW-1], sh = |D| (DW bits; the most-negative value yields 2^(DW-1)), e = 2^EW-1; next state NORM.
REQ-014 NORM: if sh[DW-1]=1 or sh[DW-2]=1 or e=0 -> ROUND; otherwise sh <<= 1, e -= 1, stay in NORM (one shift per cycle).
REQ-015 ROUND: if sh[DW-1]=1 (most-negative input), E = 2^EW-1 and F = all ones; otherwise F = sh[DW-2 -: MW] and E = e.
REQ-016 ROUND with rounding: if sh[DW-2-MW]=1 and F is not all ones, F += 1.
REQ-017 ROUND overflow: if the round bit is 1, F is all ones and E < max, then F = 2^(MW-1) and E += 1.
REQ-018 ROUND saturation: if the round bit is 1, F is all ones and E = max, then F and E are unchanged.
REQ-019 ROUND next state is DONE.
REQ-020 Latency: with k shifts in NORM, out_valid SHALL rise k+2 cycles after the accepting edge; k <= 2^EW-1.
REQ-021 DONE: S/E/F SHALL remain stable while out_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-022 in_valid SHALL be ignored outside IDLE; there is no back-to-back accept from DONE.
REQ-023 S/E/F SHALL hold the last result until the next ROUND.

Reset
REQ-024 rst=1 SHALL force IDLE, S=0, E=0, F=0, sh=0, e=0 immediately, irrespective of clk.
REQ-025 rst asserted in NORM/ROUND/DONE SHALL discard the in-flight conversion; no out_valid pulse for it after release.

Configuration
REQ-026 Macro FPCVT_ROUND_EN defined: ROUND applies REQ-016..018.
REQ-027 Macro FPCVT_ROUND_EN undefined: F is truncated (round bit ignored, E never incremented); state sequence and latency are identical.

Structure
REQ-028 Package fpcvt_pkg SHALL hold the FSM state enum typedef and the default DW/EW/MW localparams.
REQ-029 Rounding SHALL be a combinational sub-module fpcvt_round (in: F, E, round bit; out: F, E), instantiated once in ROUND logic.

Verification (DW=12, EW=3, MW=4)
REQ-030 D=0x000 -> S=0 E=0 F=0; out_valid 9 cycles after accept (k=7).
REQ-031 D=0x07D (125) with ROUND_EN -> S=0 E=4 F=8 (overflow carry), latency 6; D=0x01F -> E=2 F=8 with ROUND_EN, E=1 F=15 without.
REQ-032 D=0x800 -> S=1 E=7 F=15, latency 2; D=0x7FF -> S=0 E=7 F=15 (saturate); D=0xFFF -> S=1 E=0 F=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> S/E/F and out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-034 Assert rst during NORM for D=0x001 -> outputs 0, in_ready=1 at release, no out_valid; next D=0x0F0 -> S=0 E=4 F=15.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared types and default sizing for the iterative int-to-float converter.
package fpcvt_pkg;

    localparam int FPCVT_DW = 12;
    localparam int FPCVT_EW = 3;
    localparam int FPCVT_MW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fpcvt_round.sv
// Round-to-nearest (half up) on the truncated significand, with carry into
// the exponent and saturation at the largest representable value.
// Rounding is active only when FPCVT_ROUND_EN is defined; otherwise the
// significand is passed through truncated and the round bit is ignored.
module fpcvt_round #(
    parameter int EW = 3,
    parameter int MW = 4
) (
    input  logic [MW-1:0] i_f,
    input  logic [EW-1:0] i_e,
    input  logic          i_rb,
    output logic [MW-1:0] o_f,
    output logic [EW-1:0] o_e
);

`ifdef FPCVT_ROUND_EN
    // Increment; on all-ones significand carry into exponent or saturate.
    always_comb begin
        o_f = i_f;
        o_e = i_e;
        if (i_rb) begin
            if (i_f != '1) begin
                o_f = i_f + 1'b1;
            end else if (i_e != '1) begin
                o_f = {1'b1, {(MW-1){1'b0}}};
                o_e = i_e + 1'b1;
            end
        end
    end
`else
    logic w_unused_rb;

    // Truncation only.
    always_comb begin
        o_f         = i_f;
        o_e         = i_e;
        w_unused_rb = i_rb;
    end
`endif

endmodule

// File: rtl/fpcvt_iter.sv
// Iterative two's-complement to small-float converter.
// One normalising shift per cycle; result value = (-1)^S * F * 2^E.
// Optional rounding is enabled by defining FPCVT_ROUND_EN.
module fpcvt_iter
    import fpcvt_pkg::*;
#(
    parameter int DW = FPCVT_DW,
    parameter int EW = FPCVT_EW,
    parameter int MW = FPCVT_MW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [MW-1:0] F
);

    generate
        if (DW != MW + (1 << EW)) begin : g_bad_cfg
            $error("fpcvt_iter: DW must equal MW + 2**EW");
        end
    endgenerate

    state_t        r_state;
    state_t        w_state_nx;
    logic [DW-1:0] r_sh;
    logic [EW-1:0] r_e;
    logic          r_sgn;
    logic          r_S;
    logic [EW-1:0] r_E;
    logic [MW-1:0] r_F;

    logic [DW-1:0] w_mag;
    logic          w_norm_done;
    logic [MW-1:0] w_f_pre;
    logic [EW-1:0] w_e_pre;
    logic          w_rb;
    logic [MW-1:0] w_f_rnd;
    logic [EW-1:0] w_e_rnd;

    // Magnitude; the most-negative input wraps to 2^(DW-1), which is exactly
    // the value wanted and is caught later by sh[DW-1].
    assign w_mag       = D[DW-1] ? (~D + 1'b1) : D;
    assign w_norm_done = r_sh[DW-1] | r_sh[DW-2] | (r_e == '0);

    // Pre-rounding significand/exponent; most-negative input forces max.
    always_comb begin
        w_f_pre = r_sh[DW-2 -: MW];
        w_e_pre = r_e;
        w_rb    = r_sh[DW-2-MW];
        if (r_sh[DW-1]) begin
            w_f_pre = '1;
            w_e_pre = '1;
        end
    end

    fpcvt_round #(.EW(EW), .MW(MW)) u_round (
        .i_f  (w_f_pre),
        .i_e  (w_e_pre),
        .i_rb (w_rb),
        .o_f  (w_f_rnd),
        .o_e  (w_e_rnd)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)    w_state_nx = NORM;
            NORM:    if (w_norm_done) w_state_nx = ROUND;
            ROUND:   w_state_nx = DONE;
            DONE:    if (out_ready)   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift in NORM, publish result in ROUND.
    // Sign is staged in r_sgn so S keeps the previous result until ROUND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_e   <= '0;
            r_sgn <= 1'b0;
            r_S   <= 1'b0;
            r_E   <= '0;
            r_F   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_sgn <= D[DW-1];
                    r_sh  <= w_mag;
                    r_e   <= '1;
                end
                NORM: if (!w_norm_done) begin
                    r_sh <= r_sh << 1;
                    r_e  <= r_e - 1'b1;
                end
                ROUND: begin
                    r_S <= r_sgn;
                    r_E <= w_e_rnd;
                    r_F <= w_f_rnd;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_S;
    assign E         = r_E;
    assign F         = r_F;

endmodule

// File: tb/tb_fpcvt_iter.sv
// Self-checking bench for fpcvt_iter (DW=12, EW=3, MW=4): directed table,
// DONE hold, reset mid-conversion and randomized vectors against a model.
module tb_fpcvt_iter;

    localparam int DW = 12;
    localparam int EW = 3;
    localparam int MW = 4;
`ifdef FPCVT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] D;
    logic          out_valid;
    logic          out_ready;
    logic          S;
    logic [EW-1:0] E;
    logic [MW-1:0] F;

    int checks   = 0;
    int failures = 0;

    fpcvt_iter #(.DW(DW), .EW(EW), .MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int s;
        int e_r, f_r;
        int e_t, f_t;
        int lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: normalise |d| arithmetically, then round half-up.
    function automatic void model(input logic [DW-1:0] d, output int s,
                                  output int e, output int f, output int lat);
        int m, k, sh, fr, rb, emax, fmax;
        emax = (1 << EW) - 1;
        fmax = (1 << MW) - 1;
        s = int'(d[DW-1]);
        m = d[DW-1] ? (1 << DW) - int'(d) : int'(d);
        if (m == (1 << (DW-1))) begin
            e = emax; f = fmax; lat = 2;
            return;
        end
        k = 0;
        while (k < emax && (m << k) < (1 << (DW-2))) k++;
        sh  = m << k;
        fr  = (sh >> (DW-1-MW)) & fmax;
        rb  = (sh >> (DW-2-MW)) & 1;
        e   = emax - k;
        lat = k + 2;
        if (ROUND_EN && rb == 1) begin
            if (fr != fmax) fr++;
            else if (e < emax) begin fr = 1 << (MW-1); e++; end
        end
        f = fr;
    endfunction

    // One full transaction from IDLE: accept, time the latency, check, drain.
    task automatic run_cvt(input logic [DW-1:0] d, input int es, input int ee,
                           input int ef, input int elat, input string tag);
        int n;
        @(negedge clk);
        D = d; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, " in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        D = DW'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " S"}, int'(S), es);
        chk({tag, " E"}, int'(E), ee);
        chk({tag, " F"}, int'(F), ef);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " back to idle"}, int'(in_ready), 1);
    endtask

    vec_t tbl[$];

    initial begin
        int s, e, f, lat, ee, ef;
        bit seen;
        logic [DW-1:0] rd;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; D = '0;
        // Reset takes effect before any clock edge.
        #1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset SEF", int'({S, E, F}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{12'h000, 0, 0, 0, 0, 0, 9});
        tbl.push_back('{12'h07D, 0, 4, 8, 3, 15, 6});
        tbl.push_back('{12'h01F, 0, 2, 8, 1, 15, 8});
        tbl.push_back('{12'h800, 1, 7, 15, 7, 15, 2});
        tbl.push_back('{12'h7FF, 0, 7, 15, 7, 15, 2});
        tbl.push_back('{12'hFFF, 1, 0, 1, 0, 1, 9});
        tbl.push_back('{12'h0F0, 0, 4, 15, 4, 15, 5});
        tbl.push_back('{12'h400, 0, 7, 8, 7, 8, 2});
        tbl.push_back('{12'hF83, 1, 4, 8, 3, 15, 6});
        foreach (tbl[i])
            run_cvt(tbl[i].d, tbl[i].s,
                    ROUND_EN ? tbl[i].e_r : tbl[i].e_t,
                    ROUND_EN ? tbl[i].f_r : tbl[i].f_t,
                    tbl[i].lat, $sformatf("tbl%0d", i));

        // DONE hold: result stable under back-pressure, in_valid ignored.
        ee = ROUND_EN ? 4 : 3;
        ef = ROUND_EN ? 8 : 15;
        @(negedge clk);
        D = 12'h07D; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        chk("hold reached DONE", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            D = 12'h123;
            @(posedge clk); #1;
            chk("hold out_valid", int'(out_valid), 1);
            chk("hold in_ready", int'(in_ready), 0);
            chk("hold SEF", int'({S, E, F}), int'({1'b0, EW'(ee), MW'(ef)}));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        chk("hold release in_ready", int'(in_ready), 1);
        chk("hold release out_valid", int'(out_valid), 0);

        // Reset in NORM discards the conversion, asynchronously.
        @(negedge clk);
        D = 12'h001; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midreset in_ready", int'(in_ready), 1);
        chk("midreset SEF", int'({S, E, F}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("midreset release in_ready", int'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midreset no out_valid", int'(seen), 0);
        chk("midreset SEF held", int'({S, E, F}), 0);
        run_cvt(12'h0F0, 0, 4, 15, 5, "after reset");

        // Randomized vectors against the model.
        for (int i = 0; i < 40; i++) begin
            rd = DW'($urandom);
            if (i % 4 == 0) rd = rd >> $urandom_range(0, DW-1);
            model(rd, s, e, f, lat);
            run_cvt(rd, s, e, f, lat, $sformatf("rand D=%03h", rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
